logic_operand_stage: RTL and testbench

- Operand-delivery pipeline stage directly upstream of the scalar logic unit (AND/OR/XOR/NOR).
- Accepts decoded instructions from issue; resolves RAW hazards by forwarding from the EX and WB result buses; zero-extends 16-bit immediates for ANDI/ORI/XORI.
- Registers opA, opB and the 2-bit logic op for the logic unit.
- Valid/ready handshake on both sides, with a one-entry skid buffer so issue-side ready is registered.

---
 rtl/logic_operand_stage_pkg.sv | 21 ++
 rtl/operand_fwd_mux.sv | 31 +++
 rtl/logic_operand_stage.sv | 163 ++++++++++++++++
 tb/tb_logic_operand_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_operand_stage_pkg.sv
// rtl/logic_operand_stage_pkg.sv - scalar pipeline defines shared by the operand stage
package logic_operand_stage_pkg;

    localparam int REGIDX   = 5;
    localparam int ZERO_IDX = 0;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'd0,
        LOGIC_OR  = 2'd1,
        LOGIC_XOR = 2'd2,
        LOGIC_NOR = 2'd3
    } logic_op_e;

    // Encoding is {out_valid, skid_valid}, so the state bits are the flags themselves.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - one-operand forwarding select: EX over WB over register file
module operand_fwd_mux
    import logic_operand_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int IDX_W  = logic_operand_stage_pkg::REGIDX
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] rf_val,
    input  logic             ex_wen,
    input  logic [IDX_W-1:0] ex_dst,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             wb_wen,
    input  logic [IDX_W-1:0] wb_dst,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] val
);

    always_comb begin
        val = rf_val;
        // The zero register is hardwired, so writes to it are never forwarded.
        if (idx != IDX_W'(ZERO_IDX)) begin
            if (ex_wen && (ex_dst == idx)) begin
                val = ex_result;
            end else if (wb_wen && (wb_dst == idx)) begin
                val = wb_result;
            end
        end
    end

endmodule

// File: rtl/logic_operand_stage.sv
// rtl/logic_operand_stage.sv - operand delivery stage with forwarding and one-entry skid buffer
module logic_operand_stage
    import logic_operand_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REGIDX = logic_operand_stage_pkg::REGIDX
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_rs_val,
    input  logic [WIDTH-1:0]  in_rt_val,
    input  logic [REGIDX-1:0] in_rs_idx,
    input  logic [REGIDX-1:0] in_rt_idx,
    input  logic [15:0]       in_imm,
    input  logic              in_use_imm,
    input  logic [1:0]        in_op,
    input  logic [REGIDX-1:0] in_dst,
    input  logic              in_wen,
    input  logic              ex_wen,
    input  logic [REGIDX-1:0] ex_dst,
    input  logic [WIDTH-1:0]  ex_result,
    input  logic              wb_wen,
    input  logic [REGIDX-1:0] wb_dst,
    input  logic [WIDTH-1:0]  wb_result,
    input  logic              squash,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_opA,
    output logic [WIDTH-1:0]  out_opB,
    output logic [1:0]        out_op,
    output logic [REGIDX-1:0] out_dst,
    output logic              out_wen
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q;
    logic              accept;
    logic              load_out_in, load_out_skid, load_skid;

    logic [WIDTH-1:0]  rs_fwd, rt_fwd, opb_in;

    logic [WIDTH-1:0]  skid_a, skid_b;
    logic [1:0]        skid_op;
    logic [REGIDX-1:0] skid_dst;
    logic              skid_wen;

    operand_fwd_mux #(.WIDTH(WIDTH), .IDX_W(REGIDX)) u_fwd_rs (
        .idx       (in_rs_idx),
        .rf_val    (in_rs_val),
        .ex_wen    (ex_wen),
        .ex_dst    (ex_dst),
        .ex_result (ex_result),
        .wb_wen    (wb_wen),
        .wb_dst    (wb_dst),
        .wb_result (wb_result),
        .val       (rs_fwd)
    );

    operand_fwd_mux #(.WIDTH(WIDTH), .IDX_W(REGIDX)) u_fwd_rt (
        .idx       (in_rt_idx),
        .rf_val    (in_rt_val),
        .ex_wen    (ex_wen),
        .ex_dst    (ex_dst),
        .ex_result (ex_result),
        .wb_wen    (wb_wen),
        .wb_dst    (wb_dst),
        .wb_result (wb_result),
        .val       (rt_fwd)
    );

    assign opb_in    = in_use_imm ? {{(WIDTH-16){1'b0}}, in_imm} : rt_fwd;
    assign accept    = in_valid && in_ready_q && !squash;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (squash) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_opA <= '0;
            out_opB <= '0;
            out_op  <= '0;
            out_dst <= '0;
            out_wen <= 1'b0;
        end else if (load_out_in) begin
            out_opA <= rs_fwd;
            out_opB <= opb_in;
            out_op  <= in_op;
            out_dst <= in_dst;
            out_wen <= in_wen;
        end else if (load_out_skid) begin
            out_opA <= skid_a;
            out_opB <= skid_b;
            out_op  <= skid_op;
            out_dst <= skid_dst;
            out_wen <= skid_wen;
        end
    end

    // Operands are captured already resolved; nothing is re-forwarded while parked here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_a   <= '0;
            skid_b   <= '0;
            skid_op  <= '0;
            skid_dst <= '0;
            skid_wen <= 1'b0;
        end else if (load_skid) begin
            skid_a   <= rs_fwd;
            skid_b   <= opb_in;
            skid_op  <= in_op;
            skid_dst <= in_dst;
            skid_wen <= in_wen;
        end
    end

endmodule

// File: tb/tb_logic_operand_stage.sv
// tb/tb_logic_operand_stage.sv - self-checking bench for logic_operand_stage
module tb_logic_operand_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [31:0] in_rs_val, in_rt_val;
    logic [4:0]  in_rs_idx, in_rt_idx;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [1:0]  in_op;
    logic [4:0]  in_dst;
    logic        in_wen;
    logic        ex_wen;
    logic [4:0]  ex_dst;
    logic [31:0] ex_result;
    logic        wb_wen;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;
    logic        squash;
    logic        out_valid, out_ready;
    logic [31:0] out_opA, out_opB;
    logic [1:0]  out_op;
    logic [4:0]  out_dst;
    logic        out_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_operand_stage #(.WIDTH(32), .REGIDX(5)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .in_dst(in_dst), .in_wen(in_wen),
        .ex_wen(ex_wen), .ex_dst(ex_dst), .ex_result(ex_result),
        .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_result(wb_result),
        .squash(squash),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opA(out_opA), .out_opB(out_opB), .out_op(out_op),
        .out_dst(out_dst), .out_wen(out_wen)
    );

    typedef struct {
        logic [4:0]  rs_idx;
        logic [31:0] rs_val;
        logic [4:0]  rt_idx;
        logic [31:0] rt_val;
        logic        use_imm;
        logic [15:0] imm;
        logic [1:0]  op;
        logic        exw;
        logic [4:0]  exd;
        logic [31:0] exr;
        logic        wbw;
        logic [4:0]  wbd;
        logic [31:0] wbr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  dst;
        logic        wen;
    } txn_t;

    vec_t vecs[6];
    txn_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand rule: youngest producer wins, register 0 never forwarded.
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (ex_wen && ex_dst == idx) return ex_result;
        if (wb_wen && wb_dst == idx) return wb_result;
        return rf;
    endfunction

    task automatic set_simple(input logic [31:0] val, input logic [4:0] dst);
        in_rs_idx = 5'd1; in_rs_val = val;
        in_rt_idx = 5'd2; in_rt_val = val ^ 32'h0000_FFFF;
        in_use_imm = 1'b0; in_imm = 16'h0;
        in_op = 2'd2; in_dst = dst; in_wen = 1'b1;
        ex_wen = 1'b0; ex_dst = 5'd0; ex_result = 32'h0;
        wb_wen = 1'b0; wb_dst = 5'd0; wb_result = 32'h0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd3, 32'h11, 5'd5, 32'h22, 1'b0, 16'h0, 2'd0,
                    1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd3, 32'hBBBB, 32'hAAAA_0000, 32'h22};
        vecs[1] = '{5'd3, 32'h11, 5'd5, 32'h22, 1'b0, 16'h0, 2'd1,
                    1'b0, 5'd3, 32'hAAAA_0000, 1'b1, 5'd3, 32'hBBBB, 32'hBBBB, 32'h22};
        vecs[2] = '{5'd0, 32'h0, 5'd6, 32'h66, 1'b0, 16'h0, 2'd2,
                    1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h66};
        vecs[3] = '{5'd2, 32'h55, 5'd4, 32'h44, 1'b1, 16'h8001, 2'd1,
                    1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h1111, 32'h55, 32'h0000_8001};
        vecs[4] = '{5'd9, 32'h99, 5'd7, 32'h77, 1'b0, 16'h0, 2'd3,
                    1'b1, 5'd6, 32'h6666, 1'b1, 5'd7, 32'h1234, 32'h99, 32'h1234};
        vecs[5] = '{5'd0, 32'h77, 5'd0, 32'h88, 1'b0, 16'h0, 2'd0,
                    1'b1, 5'd0, 32'hCAFE, 1'b1, 5'd0, 32'hF00D, 32'h77, 32'h88};

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; squash = 1'b0;
        set_simple(32'h0, 5'd0);
        #12;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_opA", out_opA, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tick();
            in_rs_idx = vecs[i].rs_idx; in_rs_val = vecs[i].rs_val;
            in_rt_idx = vecs[i].rt_idx; in_rt_val = vecs[i].rt_val;
            in_use_imm = vecs[i].use_imm; in_imm = vecs[i].imm; in_op = vecs[i].op;
            in_dst = 5'(i + 10); in_wen = i[0];
            ex_wen = vecs[i].exw; ex_dst = vecs[i].exd; ex_result = vecs[i].exr;
            wb_wen = vecs[i].wbw; wb_dst = vecs[i].wbd; wb_result = vecs[i].wbr;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_opA", i), out_opA, vecs[i].exp_a);
            chk($sformatf("vec%0d_opB", i), out_opB, vecs[i].exp_b);
            chk($sformatf("vec%0d_op", i), {30'b0, out_op}, {30'b0, vecs[i].op});
            chk($sformatf("vec%0d_dst_wen", i), {26'b0, out_dst, out_wen}, {26'b0, 5'(i + 10), i[0]});
        end
        tick();

        // Backpressure fill, then drain in order.
        out_ready = 1'b0;
        set_simple(32'hA0A0_0001, 5'd1); in_valid = 1'b1;
        tick();
        chk("bp_ready_after_A", {31'b0, in_ready}, 32'd1);
        set_simple(32'hB0B0_0002, 5'd2);
        tick();
        in_valid = 1'b0;
        chk("bp_ready_after_B", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_A", out_opA, 32'hA0A0_0001);
        out_ready = 1'b1;
        tick();
        chk("bp_deliver_B", out_opA, 32'hB0B0_0002);
        chk("bp_ready_reopen", {31'b0, in_ready}, 32'd1);
        chk("bp_B_valid", {31'b0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Squash while FULL with an instruction on offer.
        out_ready = 1'b0;
        set_simple(32'hC0C0_0003, 5'd3); in_valid = 1'b1;
        tick();
        set_simple(32'hD0D0_0004, 5'd4);
        tick();
        chk("sq_full", {31'b0, in_ready}, 32'd0);
        set_simple(32'hE0E0_0005, 5'd5); squash = 1'b1;
        tick();
        squash = 1'b0; in_valid = 1'b0;
        chk("sq_out_valid", {31'b0, out_valid}, 32'd0);
        chk("sq_in_ready", {31'b0, in_ready}, 32'd1);
        set_simple(32'hF0F0_0006, 5'd6); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sq_next_valid", {31'b0, out_valid}, 32'd1);
        chk("sq_next_opA", out_opA, 32'hF0F0_0006);
        tick();
        chk("sq_next_alone", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-traffic.
        out_ready = 1'b0;
        set_simple(32'h1234_5678, 5'd7); in_valid = 1'b1;
        tick();
        set_simple(32'h9ABC_DEF0, 5'd8);
        tick();
        in_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_opA", out_opA, 32'd0);
        resetn = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rst_no_survivor", {31'b0, out_valid}, 32'd0);

        // Random stream against a queue scoreboard.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic acc;
            txn_t t;
            tick();
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            squash     = ($urandom_range(0, 29) == 0);
            in_rs_idx  = 5'($urandom_range(0, 3));
            in_rt_idx  = 5'($urandom_range(0, 3));
            in_rs_val  = $urandom; in_rt_val = $urandom;
            in_imm     = 16'($urandom); in_use_imm = $urandom_range(0, 1) == 1;
            in_op      = 2'($urandom); in_dst = 5'($urandom); in_wen = $urandom_range(0, 1) == 1;
            ex_wen     = $urandom_range(0, 1) == 1; ex_dst = 5'($urandom_range(0, 3)); ex_result = $urandom;
            wb_wen     = $urandom_range(0, 1) == 1; wb_dst = 5'($urandom_range(0, 3)); wb_result = $urandom;
            @(negedge clk);
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            if (q.size() != 0) begin
                chk("rnd_opA", out_opA, q[0].a);
                chk("rnd_opB", out_opB, q[0].b);
                chk("rnd_ctl", {24'b0, out_op, out_dst, out_wen}, {24'b0, q[0].op, q[0].dst, q[0].wen});
            end
            acc = in_valid && (q.size() < 2);
            t.a   = ref_operand(in_rs_idx, in_rs_val);
            t.b   = in_use_imm ? {16'h0, in_imm} : ref_operand(in_rt_idx, in_rt_val);
            t.op  = in_op; t.dst = in_dst; t.wen = in_wen;
            if (squash) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(t);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
